// File: rtl/cla_nibble_serial_subtractor.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit borrow-lookahead
// nibble per clock, low nibble first, behind valid/ready operand and result ports.
// Optional feature macro: CLA_SUB_OVF_EN adds the registered signed-overflow output ovf.
module cla_nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef CLA_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned POSW = IDXW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              br_q, br_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
`ifdef CLA_SUB_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [POSW-1:0]   bitpos;
    logic [3:0]        nib_a, nib_b;
    logic [3:0]        nib_g, nib_p;
    logic [4:0]        nib_br;
    logic [3:0]        nib_diff;
    logic              last_nib;

    // Bit offset of the nibble currently being processed
    assign bitpos   = {idx_q, 2'b00};
    assign nib_a    = a_q[bitpos +: 4];
    assign nib_b    = b_q[bitpos +: 4];
    assign last_nib = (idx_q == IDXW'(NIB - 1));

    // Borrow-lookahead for one nibble: every internal borrow is a flat sum of products
    always_comb begin
        nib_g     = ~nib_a & nib_b;
        nib_p     = ~(nib_a ^ nib_b);
        nib_br[0] = br_q;
        nib_br[1] = nib_g[0]
                  | (nib_p[0] & br_q);
        nib_br[2] = nib_g[1]
                  | (nib_p[1] & nib_g[0])
                  | (nib_p[1] & nib_p[0] & br_q);
        nib_br[3] = nib_g[2]
                  | (nib_p[2] & nib_g[1])
                  | (nib_p[2] & nib_p[1] & nib_g[0])
                  | (nib_p[2] & nib_p[1] & nib_p[0] & br_q);
        nib_br[4] = nib_g[3]
                  | (nib_p[3] & nib_g[2])
                  | (nib_p[3] & nib_p[2] & nib_g[1])
                  | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                  | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & br_q);
        nib_diff  = nib_a ^ nib_b ^ nib_br[3:0];
    end

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        idx_d   = idx_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef CLA_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    idx_d   = '0;
                    diff_d  = '0;
                    bout_d  = 1'b0;
`ifdef CLA_SUB_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[bitpos +: 4] = nib_diff;
                br_d                = nib_br[4];
                if (last_nib) begin
                    bout_d  = nib_br[4];
`ifdef CLA_SUB_OVF_EN
                    // Signed overflow: operand signs differ and result sign differs from a
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (nib_diff[3] ^ a_q[WIDTH-1]);
`endif
                    state_d = DONE;
                end else begin
                    idx_d   = IDXW'(idx_q + 1'b1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            idx_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            idx_q   <= idx_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

`ifdef CLA_SUB_OVF_EN
    // Overflow flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule
